// File: rtl/fifo_write_test.sv
// fifo_write_test: burst test-pattern writer for the 64-bit data FIFO (16-bit ramp across four lanes).
// Define FIFO_WRITE_TEST_ERR_INJECT_EN to add inject_err/err_cnt single-bit corruption of lane 0.
module fifo_write_test #(
   parameter int unsigned BURST_LEN  = 256,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic        write_clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        fifo_full,
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
   input  logic        inject_err,
   output logic [15:0] err_cnt,
`endif
   output logic        wr_en,
   output logic [63:0] fifo_data,
   output logic        burst_ready,
   output logic [1:0]  state,
   output logic [8:0]  write_cnt,
   output logic [8:0]  gap_cnt,
   output logic [15:0] burst_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FILL     = 2'd1,
      ANNOUNCE = 2'd2,
      GAP      = 2'd3
   } state_t;

   localparam logic [8:0] BURST_LEN_W = 9'(BURST_LEN);
   localparam logic [8:0] GAP_LAST    = 9'(GAP_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [13:0] seq;
   logic        last_write;
   logic        err_armed;

   assign wr_en       = (state_q == FILL) && !fifo_full && (write_cnt < BURST_LEN_W);
   assign last_write  = wr_en && (write_cnt == BURST_LEN_W - 9'd1);
   assign burst_ready = (state_q == ANNOUNCE);
   assign state       = state_q;

   // Data comes only from seq and the armed flag, never from inputs.
   assign fifo_data = {seq, 2'd3, seq, 2'd2, seq, 2'd1, seq, 1'b0, err_armed};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (enable) state_d = FILL;
         FILL:     if (last_write) state_d = ANNOUNCE;
         ANNOUNCE: begin
            if (GAP_CYCLES != 0) state_d = GAP;
            else                 state_d = enable ? FILL : IDLE;
         end
         GAP:      if (gap_cnt == GAP_LAST) state_d = enable ? FILL : IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge write_clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge write_clk) begin
      if (reset) begin
         seq       <= '0;
         write_cnt <= '0;
         gap_cnt   <= '0;
         burst_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (wr_en) begin
            seq       <= seq + 14'd1;
            write_cnt <= write_cnt + 9'd1;
         end
         case (state_q)
            IDLE: write_cnt <= '0;
            FILL: if (fifo_full && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
            ANNOUNCE: begin
               burst_cnt <= burst_cnt + 16'd1;
               gap_cnt   <= '0;
               if (state_d == FILL) write_cnt <= '0;
            end
            GAP: begin
               gap_cnt <= gap_cnt + 9'd1;
               if (gap_cnt == GAP_LAST) write_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
   logic inject_q;

   // A new rising edge in the same cycle as the corrupted write re-arms the flag.
   always_ff @(posedge write_clk) begin
      if (reset) begin
         inject_q  <= 1'b0;
         err_armed <= 1'b0;
         err_cnt   <= '0;
      end else begin
         inject_q <= inject_err;
         if (wr_en && err_armed) begin
            err_armed <= 1'b0;
            err_cnt   <= err_cnt + 16'd1;
         end
         if (inject_err && !inject_q) err_armed <= 1'b1;
      end
   end
`else
   assign err_armed = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_test.sv
// Self-checking bench for fifo_write_test: directed scenarios plus $urandom stimulus against a spec-level model.
// Honours FIFO_WRITE_TEST_ERR_INJECT_EN when defined.
module tb_fifo_write_test;

   localparam int BL = 256;
   localparam int GC = 16;
   localparam int M_IDLE = 0, M_FILL = 1, M_ANN = 2, M_GAP = 3;

   logic        write_clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        fifo_full = 1'b0;
   logic        wr_en;
   logic [63:0] fifo_data;
   logic        burst_ready;
   logic [1:0]  state;
   logic [8:0]  write_cnt;
   logic [8:0]  gap_cnt;
   logic [15:0] burst_cnt;
   logic [15:0] stall_cnt;
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
   logic        inject_err = 1'b0;
   logic [15:0] err_cnt;
`endif

   always #5 write_clk = ~write_clk;

   fifo_write_test #(.BURST_LEN(BL), .GAP_CYCLES(GC)) dut (
      .write_clk   (write_clk),
      .reset       (reset),
      .enable      (enable),
      .fifo_full   (fifo_full),
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
      .inject_err  (inject_err),
      .err_cnt     (err_cnt),
`endif
      .wr_en       (wr_en),
      .fifo_data   (fifo_data),
      .burst_ready (burst_ready),
      .state       (state),
      .write_cnt   (write_cnt),
      .gap_cnt     (gap_cnt),
      .burst_cnt   (burst_cnt),
      .stall_cnt   (stall_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Spec-level model: phase, counters, and the index of the next ramp word.
   int m_mode = M_IDLE, m_wc = 0, m_gc = 0, m_bc = 0, m_sc = 0, m_n = 0;
   int m_ec = 0;
   bit m_flag = 0, m_prev = 0;

   longint    cyc_no = 0;
   logic [63:0] wlog[$];
   longint    start_q[$];
   longint    ready_q[$];
   longint    last_wr = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
      end
   endtask

   function automatic logic [63:0] exp_data();
      logic [63:0] d;
      for (int k = 0; k < 4; k++) d[16*k +: 16] = 16'((4 * m_n + k) % 65536);
      if (m_flag) d[0] = ~d[0];
      return d;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic f, input logic i);
      bit acc;
      acc = (m_mode == M_FILL) && !f && (m_wc < BL);
      if (r) begin
         m_mode = M_IDLE; m_wc = 0; m_gc = 0; m_bc = 0; m_sc = 0; m_n = 0;
         m_ec = 0; m_flag = 0; m_prev = 0;
      end else begin
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
         if (acc && m_flag) begin
            m_flag = 0;
            m_ec = (m_ec + 1) % 65536;
         end
         if (i && !m_prev) m_flag = 1;
         m_prev = i;
`endif
         if (acc) begin
            m_n = (m_n + 1) % 16384;
            m_wc++;
         end
         case (m_mode)
            M_IDLE: begin
               m_wc = 0;
               if (e) m_mode = M_FILL;
            end
            M_FILL: begin
               if (f && m_sc < 65535) m_sc++;
               if (m_wc == BL) m_mode = M_ANN;
            end
            M_ANN: begin
               m_bc = (m_bc + 1) % 65536;
               m_gc = 0;
               if (GC > 0) m_mode = M_GAP;
               else if (e) begin m_wc = 0; m_mode = M_FILL; end
               else m_mode = M_IDLE;
            end
            default: begin
               if (m_gc == GC - 1) begin
                  m_wc = 0;
                  m_mode = e ? M_FILL : M_IDLE;
               end
               m_gc++;
            end
         endcase
      end
   endtask

   // One clock: drive inputs at negedge, compare every output, advance the model on the posedge.
   task automatic cyc(input logic r, input logic e, input logic f, input logic i);
      bit exp_wr;
      @(negedge write_clk);
      reset = r; enable = e; fifo_full = f;
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
      inject_err = i;
`endif
      #1;
      exp_wr = (m_mode == M_FILL) && !f && (m_wc < BL);
      check("wr_en",       64'(wr_en),       64'(exp_wr));
      check("fifo_data",   fifo_data,        exp_data());
      check("burst_ready", 64'(burst_ready), 64'(m_mode == M_ANN));
      check("state",       64'(state),       64'(m_mode));
      check("write_cnt",   64'(write_cnt),   64'(m_wc));
      check("gap_cnt",     64'(gap_cnt),     64'(m_gc));
      check("burst_cnt",   64'(burst_cnt),   64'(m_bc));
      check("stall_cnt",   64'(stall_cnt),   64'(m_sc));
`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
      check("err_cnt",     64'(err_cnt),     64'(m_ec));
`endif
      if (wr_en) begin
         if (write_cnt == 9'd0) start_q.push_back(cyc_no);
         wlog.push_back(fifo_data);
         last_wr = cyc_no;
      end
      if (burst_ready) ready_q.push_back(cyc_no);
      @(posedge write_clk);
      model_step(r, e, f, i);
      cyc_no++;
      if (r) begin
         wlog.delete(); start_q.delete(); ready_q.delete();
      end
      if (n_errors > 100) begin
         $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
         $finish;
      end
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      // Reset state
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      settle();
      check("rst_data", fifo_data, 64'h0003_0002_0001_0000);
      check("rst_wr_en", 64'(wr_en), 64'd0);

      // First burst with clean FIFO
      for (int k = 0; k < 400 && m_bc < 1; k++) cyc(0, 1, 0, 0);
      check("tmo_burst1", 64'(m_bc), 64'd1);
      check("b1_words", 64'(wlog.size()), 64'd256);
      check("b1_first", wlog[0], 64'h0003_0002_0001_0000);
      check("b1_last", wlog[255], 64'h03FF_03FE_03FD_03FC);
      check("b1_contig", 64'(last_wr - start_q[0]), 64'd255);
      check("b1_ready_lat", 64'(ready_q[0] - last_wr), 64'd1);
      settle();
      check("b1_burst_cnt", 64'(burst_cnt), 64'd1);

      // Continuous enable through three bursts
      for (int k = 0; k < 1000 && m_bc < 3; k++) cyc(0, 1, 0, 0);
      check("tmo_burst3", 64'(m_bc), 64'd3);
      check("b2_start_gap", 64'(start_q[1] - ready_q[0]), 64'd17);
      check("b2_first", wlog[256], 64'h0403_0402_0401_0400);
      settle();
      check("b3_burst_cnt", 64'(burst_cnt), 64'd3);

      // fifo_full held 10 cycles after write 100
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 200 && !(m_mode == M_FILL && m_wc == 100); k++) cyc(0, 1, 0, 0);
      check("tmo_w100", 64'(m_wc), 64'd100);
      for (int k = 0; k < 10; k++) cyc(0, 1, 1, 0);
      settle();
      check("stall_cnt10", 64'(stall_cnt), 64'd10);
      for (int k = 0; k < 400 && m_bc < 1; k++) cyc(0, 1, 0, 0);
      check("stall_words", 64'(wlog.size()), 64'd256);
      check("stall_w100", wlog[100], 64'h0193_0192_0191_0190);
      check("stall_last", wlog[255], 64'h03FF_03FE_03FD_03FC);

      // enable dropped at write 50
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 200 && !(m_mode == M_FILL && m_wc == 50); k++) cyc(0, 1, 0, 0);
      check("tmo_w50", 64'(m_wc), 64'd50);
      for (int k = 0; k < 400 && !(m_bc == 1 && m_mode == M_IDLE); k++) cyc(0, 0, 0, 0);
      check("drop_words", 64'(wlog.size()), 64'd256);
      check("drop_ready", 64'(ready_q.size()), 64'd1);
      cyc(0, 0, 0, 0);
      settle();
      check("drop_state", 64'(state), 64'd0);
      check("drop_wr_en", 64'(wr_en), 64'd0);

      // reset at write 128 of burst 2
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 800 && !(m_bc == 1 && m_mode == M_FILL && m_wc == 128); k++) cyc(0, 1, 0, 0);
      check("tmo_b2w128", 64'(m_wc), 64'd128);
      cyc(1, 1, 0, 0);
      settle();
      check("mid_rst_state", 64'(state), 64'd0);
      check("mid_rst_counts", {15'd0, write_cnt, 7'd0, gap_cnt, burst_cnt, stall_cnt}, 64'd0);
      check("mid_rst_ready", 64'(burst_ready), 64'd0);
      for (int k = 0; k < 10 && wlog.size() == 0; k++) cyc(0, 1, 0, 0);
      check("mid_rst_first", wlog[0], 64'h0003_0002_0001_0000);

`ifdef FIFO_WRITE_TEST_ERR_INJECT_EN
      // Error injection pulsed during GAP
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 400 && !(m_mode == M_GAP && m_gc == 3); k++) cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 1);
      for (int k = 0; k < 100 && wlog.size() < 258; k++) cyc(0, 1, 0, 0);
      check("inj_word", wlog[256], 64'h0403_0402_0401_0401);
      check("inj_clean", wlog[257], 64'h0407_0406_0405_0404);
      settle();
      check("inj_err_cnt", 64'(err_cnt), 64'd1);
`endif

      // Randomised traffic: long reset-free stretch wraps the ramp, then occasional resets
      cyc(1, 0, 0, 0);
      for (int k = 0; k < 26000; k++) begin
         logic r, e, f, i;
         r = (k > 23000) && ($urandom_range(0, 2999) == 0);
         e = ($urandom_range(0, 9) != 0);
         f = ($urandom_range(0, 9) == 0);
         i = ($urandom_range(0, 199) == 0);
         cyc(r, e, f, i);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_write_test.md
Name: fifo_write_test

Overview:
- Test-pattern source for the 64-bit data FIFO; the write-side counterpart to the burst reader on the far side.
- Fills the FIFO in fixed bursts of BURST_LEN words, respecting fifo_full.
- Pulses burst_ready once per completed burst, then idles GAP_CYCLES before starting the next burst.
- Data is a contiguous 16-bit ramp across the four lanes, so the reader can check every lane sample.

Parameters:
BURST_LEN, 256, words written per burst (1..256)
GAP_CYCLES, 16, idle cycles after each burst_ready pulse (0..511)

Ports:
write_clk  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset; one clock, write_clk, sampled on its rising edge
enable  in  1  level; start or continue bursts while high
fifo_full  in  1  FIFO full flag, write-clock domain
wr_en  out  1  FIFO write enable (combinational)
fifo_data  out  64  {wdata_3, wdata_2, wdata_1, wdata_0}
burst_ready  out  1  one-cycle pulse: BURST_LEN words are now in FIFO
state  out  2  FSM state code
write_cnt  out  9  accepted writes in current burst
gap_cnt  out  9  idle cycles elapsed in GAP
burst_cnt  out  16  completed bursts, wraps
stall_cnt  out  16  FILL cycles blocked by fifo_full, saturates at 0xFFFF

Behaviour:
- Reset (sync): state=IDLE, seq=0, write_cnt=0, gap_cnt=0, burst_cnt=0, stall_cnt=0.
  - Hence wr_en=0, burst_ready=0, fifo_data=0x0003_0002_0001_0000.
- Pattern: 14-bit register seq; lane k = {seq, k[1:0]}, i.e. 4*seq+k.
  - seq increments by 1 per accepted write.
  - Wraps 0x3FFF->0; lane values wrap 0xFFFF->0x0000 seamlessly.
- wr_en = (state==FILL) && !fifo_full && (write_cnt < BURST_LEN).
  - A write is accepted on any rising edge with wr_en=1.
  - fifo_data is valid whenever wr_en=1 and is driven from registers only (no input-to-data path).
- FSM, codes IDLE=0, FILL=1, ANNOUNCE=2, GAP=3:
  - IDLE: wr_en=0, write_cnt<=0. If enable, go to FILL next cycle.
  - FILL:
    - On an accepted write: write_cnt++.
    - When fifo_full=1: stall_cnt++ (saturating), no write, seq held.
    - When the accepted write makes write_cnt==BURST_LEN, go to ANNOUNCE.
    - enable deasserting mid-burst is ignored; no partial bursts.
  - ANNOUNCE (exactly 1 cycle): burst_ready=1, burst_cnt++, gap_cnt<=0.
    - Next state: GAP if GAP_CYCLES>0.
    - Otherwise, if GAP_CYCLES==0: FILL (write_cnt<=0) if enable, else IDLE.
  - GAP: gap_cnt++ each cycle.
    - When gap_cnt==GAP_CYCLES-1, write_cnt<=0 and go to FILL if enable, else IDLE.
- Throughput: with fifo_full=0, a burst takes exactly BURST_LEN FILL cycles.
  - Burst period is 1 (IDLE) + BURST_LEN + 1 + GAP_CYCLES cycles from enable rise.
  - Back-to-back bursts: BURST_LEN + 1 + GAP_CYCLES cycles each.
- fifo_full asserted on the last word: that word is held until full drops; ANNOUNCE follows its acceptance.
- reset asserted at any time (mid-FILL, ANNOUNCE, GAP) returns to reset values on that edge.
  - seq restarts at 0; no burst_ready is emitted for the partial burst.
- Unused state codes: none reachable. Any illegal encoding goes to IDLE on the next edge.

Optional Feature:
- Macro: FIFO_WRITE_TEST_ERR_INJECT_EN.
- Defined:
  - Adds port inject_err (in, 1) and output err_cnt (out, 16, wraps).
  - A rising edge on inject_err arms a flag.
  - The next accepted write has wdata_0 bit 0 inverted, then the flag clears and err_cnt++.
  - seq advances normally; the flag clears on reset.
- Not defined: ports absent; data is always the clean pattern.

Test Plan:
- Reset, then enable=1, fifo_full=0, defaults:
  - wr_en high for 256 consecutive cycles.
  - First word 0x0003_0002_0001_0000, last word 0x03FF_03FE_03FD_03FC.
  - burst_ready pulses exactly 1 cycle after the last write; burst_cnt=1.
- Continuous enable over 3 bursts:
  - Next burst starts exactly 17 cycles after the burst_ready cycle.
  - Second burst's first word is 0x0403_0402_0401_0400; burst_cnt=3.
- fifo_full=1 for 10 cycles mid-burst (after write 100):
  - wr_en=0 during those cycles, fifo_data held, stall_cnt=10.
  - Still exactly 256 writes with no gaps in the ramp.
- enable dropped at write 50: burst completes all 256 writes and burst_ready fires; FSM then waits in GAP and settles in IDLE with wr_en=0.
- reset at write 128 of burst 2: next cycle all counters are 0 and state=IDLE; after enable, the first word is again 0x0003_0002_0001_0000.
- With FIFO_WRITE_TEST_ERR_INJECT_EN: pulse inject_err during GAP; the first word of the next burst has wdata_0 XOR 0x0001; err_cnt=1; the following word is clean.
